if_fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline: owns the program counter, the instruction memory and the IF/ID pipeline register, and feeds the decode stage `instruction` and `PC_IFID`. It consumes the branch redirect (`PCSrc_MEMIF`, `PCJump`) produced by the MEM stage and a stall request from the hazard unit. A write port loads the program image before or during simulation.

---
 rtl/if_fetch_stage.sv | 104 ++++++++++
 tb/tb_if_fetch_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, instruction memory and IF/ID register for the MIPS pipeline.
// Define IF_BRANCH_FLUSH_EN to squash the wrong-path word on a redirect and pass through FLUSH.
module if_fetch_stage #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [9:0]  RESET_PC   = 10'd0,
  parameter logic [31:0] NOP        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        PCSrc_MEMIF,
  input  logic [9:0]  PCJump,
  input  logic        imem_we,
  input  logic [7:0]  imem_waddr,
  input  logic [31:0] imem_wdata,
  output logic [9:0]  PC,
  output logic [31:0] instruction,
  output logic [9:0]  PC_IFID,
  output logic        valid_IFID,
  output logic [15:0] fetch_count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t      r_state;
  logic [9:0]  r_pc;
  logic [31:0] r_instr;
  logic [9:0]  r_pc_ifid;
  logic        r_valid;
  logic [15:0] r_count;
  logic [31:0] r_imem [IMEM_DEPTH];

  logic [7:0]  w_ridx;
  logic [31:0] w_fetch;
  logic [9:0]  w_pc_plus4;
  logic [9:0]  w_target;

  assign w_ridx     = r_pc[9:2];
  assign w_fetch    = r_imem[w_ridx];
  assign w_pc_plus4 = r_pc + 10'd4;
  assign w_target   = PCJump & 10'h3FC;

  // Memory is never reset so a program loaded during reset survives it.
  always_ff @(posedge clk) begin
    if (imem_we) r_imem[imem_waddr] <= imem_wdata;
  end

  // stall acts as "decode not ready": PC and IF/ID hold; a redirect overrides it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_BOOT;
      r_pc      <= RESET_PC;
      r_instr   <= NOP;
      r_pc_ifid <= 10'd0;
      r_valid   <= 1'b0;
      r_count   <= 16'd0;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        ST_RUN, ST_FLUSH: begin
          if (PCSrc_MEMIF) begin
            r_pc <= w_target;
`ifdef IF_BRANCH_FLUSH_EN
            r_instr   <= NOP;
            r_pc_ifid <= 10'd0;
            r_valid   <= 1'b0;
            r_state   <= ST_FLUSH;
`else
            // Delay-slot semantics: the sequential word is still captured.
            r_instr   <= w_fetch;
            r_pc_ifid <= w_pc_plus4;
            r_valid   <= 1'b1;
            r_count   <= r_count + 16'd1;
            r_state   <= ST_RUN;
`endif
          end else if (stall) begin
            r_state <= ST_RUN;
          end else begin
            r_instr   <= w_fetch;
            r_pc_ifid <= w_pc_plus4;
            r_valid   <= 1'b1;
            r_pc      <= w_pc_plus4;
            r_count   <= r_count + 16'd1;
            r_state   <= ST_RUN;
          end
        end
        default: r_state <= ST_BOOT;
      endcase
    end
  end

  assign PC          = r_pc;
  assign instruction = r_instr;
  assign PC_IFID     = r_pc_ifid;
  assign valid_IFID  = r_valid;
  assign fetch_count = r_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage; expectations follow IF_BRANCH_FLUSH_EN if defined.
module tb_if_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        PCSrc_MEMIF;
  logic [9:0]  PCJump;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [9:0]  PC;
  logic [31:0] instruction;
  logic [9:0]  PC_IFID;
  logic        valid_IFID;
  logic [15:0] fetch_count;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_cnt;

  if_fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .PCSrc_MEMIF(PCSrc_MEMIF), .PCJump(PCJump),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .PC(PC), .instruction(instruction), .PC_IFID(PC_IFID), .valid_IFID(valid_IFID),
    .fetch_count(fetch_count), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word i of the program image is 0x20010001 + i.
  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; PCSrc_MEMIF = 1'b0; PCJump = 10'd0;
    imem_we = 1'b0; imem_waddr = 8'd0; imem_wdata = 32'd0;
    for (int i = 0; i < 256; i++) begin
      imem_we = 1'b1; imem_waddr = 8'(i); imem_wdata = 32'h2001_0001 + 32'(i);
      tick();
    end
    imem_we = 1'b0;
    checks++; if (PC !== 10'h000) begin errors++; $display("FAIL reset_pc: got %h want 000", PC); end
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instruction); end
    checks++; if (PC_IFID !== 10'h000) begin errors++; $display("FAIL reset_pc_ifid: got %h want 000", PC_IFID); end
    checks++; if (valid_IFID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_IFID); end
    checks++; if (fetch_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    reset = 1'b1;
    tick();
    checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL boot_state: got %0d want 1", dbg_state); end
    checks++; if (valid_IFID !== 1'b0 || PC !== 10'h000) begin errors++; $display("FAIL boot_hold: got valid=%b pc=%h want 0/000", valid_IFID, PC); end
    tick();
    checks++; if (instruction !== 32'h2001_0001) begin errors++; $display("FAIL boot_first_instr: got %h want 20010001", instruction); end
    checks++; if (PC_IFID !== 10'h004) begin errors++; $display("FAIL boot_first_pc_ifid: got %h want 004", PC_IFID); end
    checks++; if (valid_IFID !== 1'b1) begin errors++; $display("FAIL boot_first_valid: got %b want 1", valid_IFID); end
    tick(); tick(); tick();
    checks++; if (instruction !== 32'h2001_0004) begin errors++; $display("FAIL edge5_instr: got %h want 20010004", instruction); end
    checks++; if (PC_IFID !== 10'h010) begin errors++; $display("FAIL edge5_pc_ifid: got %h want 010", PC_IFID); end
    checks++; if (fetch_count !== 16'd4) begin errors++; $display("FAIL edge5_count: got %0d want 4", fetch_count); end
    exp_cnt = 16'd4;
  endtask

  // PC=0x010 on entry.
  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (PC !== 10'h010 || instruction !== 32'h2001_0004 || fetch_count !== 16'd4)
        begin errors++; $display("FAIL stall_hold%0d: got pc=%h instr=%h cnt=%0d want 010/20010004/4", i, PC, instruction, fetch_count); end
    end
    stall = 1'b0;
    tick();
    checks++; if (instruction !== 32'h2001_0005 || PC_IFID !== 10'h014 || PC !== 10'h014)
      begin errors++; $display("FAIL stall_release: got instr=%h pc_ifid=%h pc=%h want 20010005/014/014", instruction, PC_IFID, PC); end
    exp_cnt = 16'd5;
    checks++; if (fetch_count !== exp_cnt) begin errors++; $display("FAIL stall_release_count: got %0d want %0d", fetch_count, exp_cnt); end
  endtask

  // PC=0x014 on entry.
  task automatic test_redirect();
    PCSrc_MEMIF = 1'b1; PCJump = 10'h040;
    tick();
    PCSrc_MEMIF = 1'b0;
    checks++; if (PC !== 10'h040) begin errors++; $display("FAIL redirect_pc: got %h want 040", PC); end
`ifdef IF_BRANCH_FLUSH_EN
    checks++; if (valid_IFID !== 1'b0 || instruction !== 32'h0 || PC_IFID !== 10'h000 || dbg_state !== 2'd2)
      begin errors++; $display("FAIL redirect_flush: got valid=%b instr=%h pc_ifid=%h st=%0d want 0/0/000/2", valid_IFID, instruction, PC_IFID, dbg_state); end
`else
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (valid_IFID !== 1'b1 || instruction !== 32'h2001_0006 || PC_IFID !== 10'h018 || dbg_state !== 2'd1)
      begin errors++; $display("FAIL redirect_slot: got valid=%b instr=%h pc_ifid=%h st=%0d want 1/20010006/018/1", valid_IFID, instruction, PC_IFID, dbg_state); end
`endif
    checks++; if (fetch_count !== exp_cnt) begin errors++; $display("FAIL redirect_count: got %0d want %0d", fetch_count, exp_cnt); end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (instruction !== 32'h2001_0011 || PC_IFID !== 10'h044 || PC !== 10'h044 || dbg_state !== 2'd1)
      begin errors++; $display("FAIL redirect_target: got instr=%h pc_ifid=%h pc=%h st=%0d want 20010011/044/044/1", instruction, PC_IFID, PC, dbg_state); end
    checks++; if (fetch_count !== exp_cnt) begin errors++; $display("FAIL redirect_target_count: got %0d want %0d", fetch_count, exp_cnt); end
  endtask

  // PC=0x044 on entry; misaligned target must be aligned down.
  task automatic test_redirect_stall();
    PCSrc_MEMIF = 1'b1; stall = 1'b1; PCJump = 10'h043;
    tick();
    PCSrc_MEMIF = 1'b0; stall = 1'b0;
    checks++; if (PC !== 10'h040) begin errors++; $display("FAIL redir_stall_pc: got %h want 040", PC); end
`ifdef IF_BRANCH_FLUSH_EN
    checks++; if (valid_IFID !== 1'b0) begin errors++; $display("FAIL redir_stall_valid: got %b want 0", valid_IFID); end
`else
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (instruction !== 32'h2001_0012 || PC_IFID !== 10'h048)
      begin errors++; $display("FAIL redir_stall_slot: got instr=%h pc_ifid=%h want 20010012/048", instruction, PC_IFID); end
`endif
    tick();
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (instruction !== 32'h2001_0011 || PC !== 10'h044)
      begin errors++; $display("FAIL redir_stall_target: got instr=%h pc=%h want 20010011/044", instruction, PC); end
    checks++; if (fetch_count !== exp_cnt) begin errors++; $display("FAIL redir_stall_count: got %0d want %0d", fetch_count, exp_cnt); end
  endtask

  task automatic test_wrap();
    PCSrc_MEMIF = 1'b1; PCJump = 10'h3FC;
    tick();
    PCSrc_MEMIF = 1'b0;
`ifndef IF_BRANCH_FLUSH_EN
    exp_cnt = exp_cnt + 16'd1;
`endif
    checks++; if (PC !== 10'h3FC) begin errors++; $display("FAIL wrap_target_pc: got %h want 3fc", PC); end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (instruction !== 32'h2001_0100 || PC_IFID !== 10'h000 || PC !== 10'h000)
      begin errors++; $display("FAIL wrap_last_word: got instr=%h pc_ifid=%h pc=%h want 20010100/000/000", instruction, PC_IFID, PC); end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (instruction !== 32'h2001_0001 || PC_IFID !== 10'h004)
      begin errors++; $display("FAIL wrap_first_word: got instr=%h pc_ifid=%h want 20010001/004", instruction, PC_IFID); end
    checks++; if (fetch_count !== exp_cnt) begin errors++; $display("FAIL wrap_count: got %0d want %0d", fetch_count, exp_cnt); end
  endtask

  // PC=0x004 on entry: overwrite word 1 on the edge that fetches it.
  task automatic test_write_fetch_same_word();
    imem_we = 1'b1; imem_waddr = 8'd1; imem_wdata = 32'hDEAD_BEEF;
    tick();
    imem_we = 1'b0;
    checks++; if (instruction !== 32'h2001_0002) begin errors++; $display("FAIL wr_same_old: got %h want 20010002", instruction); end
    PCSrc_MEMIF = 1'b1; PCJump = 10'h004;
    tick();
    PCSrc_MEMIF = 1'b0;
    tick();
    checks++; if (instruction !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_same_new: got %h want deadbeef", instruction); end
  endtask

  task automatic test_async_reset();
    #2;
    reset = 1'b0;
    #1;
    checks++; if (PC !== 10'h000 || instruction !== 32'h0 || PC_IFID !== 10'h000)
      begin errors++; $display("FAIL async_rst_regs: got pc=%h instr=%h pc_ifid=%h want 000/0/000", PC, instruction, PC_IFID); end
    checks++; if (valid_IFID !== 1'b0 || fetch_count !== 16'd0 || dbg_state !== 2'd0)
      begin errors++; $display("FAIL async_rst_ctrl: got valid=%b cnt=%0d st=%0d want 0/0/0", valid_IFID, fetch_count, dbg_state); end
    tick();
    reset = 1'b1;
    tick(); tick();
    checks++; if (instruction !== 32'h2001_0001) begin errors++; $display("FAIL async_rst_word0: got %h want 20010001", instruction); end
    tick();
    checks++; if (instruction !== 32'hDEAD_BEEF || fetch_count !== 16'd2)
      begin errors++; $display("FAIL async_rst_retained: got instr=%h cnt=%0d want deadbeef/2", instruction, fetch_count); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_write_fetch_same_word();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
